// File: rtl/spi_dev_pkg.sv
// -----------------------------------------------------------------------------
// spi_dev_pkg
// Shared definitions for the DCFEB on-board SPI device master:
//   - device-select codes for the comparator DAC, calibration DAC and
//     calibration ADC
//   - the controller FSM state enumeration
//   - the default maximum transfer length
//   - is_active(): true for states in which a device enable is asserted
// -----------------------------------------------------------------------------
package spi_dev_pkg;

  localparam int MAX_BITS_DEFAULT = 24;

  localparam logic [1:0] DEV_CDAC   = 2'd0;
  localparam logic [1:0] DEV_CALDAC = 2'd1;
  localparam logic [1:0] DEV_CALADC = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    HIGH   = 3'd2,
    LOW    = 3'd3,
    HOLD   = 3'd4,
    REJECT = 3'd5
  } spi_state_e;

  // States during which the selected device enable (and BUSY) are high.
  function automatic logic is_active(input spi_state_e s);
    return (s == SETUP) || (s == HIGH) || (s == LOW) || (s == HOLD);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// -----------------------------------------------------------------------------
// spi_phase_timer
// Counts 0..CLK_DIV-1 and flags the terminal count. Every SPI phase (setup,
// clock high, clock low, hold) lasts exactly one full count, so the owner
// reloads the timer whenever its state changes.
//
// Ports:
//   clk     in  system clock
//   srst    in  synchronous active-high reset
//   reload  in  restart the count at 0 on the next edge
//   tick    out high during the last cycle of the current phase
// -----------------------------------------------------------------------------
module spi_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic reload,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || reload || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == TERM);

endmodule

// File: rtl/spi_dev_ctrl.sv
// -----------------------------------------------------------------------------
// spi_dev_ctrl
// SPI master (mode 0, MSB first) for the DCFEB comparator DAC, calibration DAC
// and calibration ADC. Accepts one request at a time, drives the active-high
// device enable, SPI clock and data, and returns the word shifted in on
// SPI_RTN. The downstream pad stage inverts enables into chip selects.
//
// Parameters:
//   CLK_DIV   CLK cycles per SPI clock half-period (2..255, 3..255 when the
//             return synchronizer is built)
//   MAX_BITS  width of TX_DATA/RX_DATA and longest transfer
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   START              one-cycle request, only sampled in IDLE
//   DEV_SEL, NBITS     target device (3 illegal), length 1..MAX_BITS
//   TX_DATA            right-justified outgoing word
//   BUSY, DONE, ERR    status; ERR is meaningful only with DONE
//   RX_DATA            right-justified received word
//   SPI_RTN            serial return line
//   SPI_CK, SPI_DAT    SPI clock (idles low) and data
//   CDAC_ENB, CALDAC_ENB, CALADC_ENB   device enables
//
// Build option:
//   SPI_RTN_SYNC_EN  adds a 2-flop synchronizer on SPI_RTN (needs CLK_DIV >= 3)
// -----------------------------------------------------------------------------
module spi_dev_ctrl
  import spi_dev_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = MAX_BITS_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [1:0]          DEV_SEL,
  input  logic [4:0]          NBITS,
  input  logic [MAX_BITS-1:0] TX_DATA,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [MAX_BITS-1:0] RX_DATA,
  input  logic                SPI_RTN,
  output logic                SPI_CK,
  output logic                SPI_DAT,
  output logic                CDAC_ENB,
  output logic                CALDAC_ENB,
  output logic                CALADC_ENB
);

  spi_state_e state_reg, state_next;

  logic                pending_reg;   // request latched, SETUP starts next edge
  logic [1:0]          dev_reg;
  logic [4:0]          bit_cnt_reg;
  logic [MAX_BITS-1:0] tx_shift_reg;  // left-aligned: MSB is next bit out
  logic [MAX_BITS-1:0] rx_shift_reg;
  logic [MAX_BITS-1:0] rx_data_reg;
  logic                busy_reg, done_reg, err_reg, ck_reg, dat_reg;
  logic [2:0]          enb_reg;
  logic [2:0]          enb_next;

  logic                tick;
  logic                rtn_sample;
  logic                req_ok;
  logic [MAX_BITS-1:0] tx_align;
  logic                accept, reject, shift_en, finish;

  // ---------------------------------------------------------------------------
  // Return path
  // ---------------------------------------------------------------------------
`ifdef SPI_RTN_SYNC_EN
  logic rtn_meta_reg, rtn_sync_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rtn_meta_reg <= 1'b0;
      rtn_sync_reg <= 1'b0;
    end else begin
      rtn_meta_reg <= SPI_RTN;
      rtn_sync_reg <= rtn_meta_reg;
    end
  end

  assign rtn_sample = rtn_sync_reg;

  // Two cycles of synchronizer latency must fit inside one high phase.
  if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_div_chk
    $error("spi_dev_ctrl: CLK_DIV must be 3..255 with SPI_RTN_SYNC_EN");
  end
`else
  assign rtn_sample = SPI_RTN;

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_div_chk
    $error("spi_dev_ctrl: CLK_DIV must be 2..255");
  end
`endif

  if (MAX_BITS < 2 || MAX_BITS > 31) begin : g_bits_chk
    $error("spi_dev_ctrl: MAX_BITS must be 2..31");
  end

  // ---------------------------------------------------------------------------
  // Phase timer, restarted on every state change
  // ---------------------------------------------------------------------------
  spi_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk    (CLK),
    .srst   (RST),
    .reload (state_next != state_reg),
    .tick   (tick)
  );

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign req_ok = (DEV_SEL != 2'd3) && (NBITS != 5'd0) && (int'(NBITS) <= MAX_BITS);

  // Left-align the word so the first bit out is always the MSB of the shifter.
  always_comb begin
    tx_align = '0;
    if (req_ok) begin
      tx_align = TX_DATA << (MAX_BITS - int'(NBITS));
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    reject     = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = SETUP;
        end else if (START && !done_reg) begin
          // A START during the DONE cycle is dropped, never queued.
          if (req_ok) begin
            accept = 1'b1;
          end else begin
            reject     = 1'b1;
            state_next = REJECT;
          end
        end
      end
      SETUP: begin
        if (tick) state_next = HIGH;
      end
      HIGH: begin
        if (tick) begin
          shift_en   = 1'b1;
          state_next = (bit_cnt_reg == 5'd1) ? HOLD : LOW;
        end
      end
      LOW: begin
        if (tick) state_next = HIGH;
      end
      HOLD: begin
        if (tick) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      REJECT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One enable per device, decoded from the latched selection.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_enb
      assign enb_next[gi] = is_active(state_next) && (dev_reg == 2'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State, datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      pending_reg  <= 1'b0;
      dev_reg      <= DEV_CDAC;
      bit_cnt_reg  <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      ck_reg       <= 1'b0;
      dat_reg      <= 1'b0;
      enb_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= accept;

      if (accept) begin
        dev_reg      <= DEV_SEL;
        bit_cnt_reg  <= NBITS;
        tx_shift_reg <= tx_align;
        rx_shift_reg <= '0;
      end else if (shift_en) begin
        bit_cnt_reg  <= bit_cnt_reg - 5'd1;
        tx_shift_reg <= {tx_shift_reg[MAX_BITS-2:0], 1'b0};
        rx_shift_reg <= {rx_shift_reg[MAX_BITS-2:0], rtn_sample};
      end

      // Data changes only as the clock goes (or stays) low.
      if (pending_reg) begin
        dat_reg <= tx_shift_reg[MAX_BITS-1];
      end else if (shift_en && bit_cnt_reg != 5'd1) begin
        dat_reg <= tx_shift_reg[MAX_BITS-2];
      end

      if (finish) begin
        rx_data_reg <= rx_shift_reg;
      end

      busy_reg <= is_active(state_next);
      ck_reg   <= (state_next == HIGH);
      enb_reg  <= enb_next;
      done_reg <= reject || finish;
      err_reg  <= reject;
    end
  end

  assign BUSY       = busy_reg;
  assign DONE       = done_reg;
  assign ERR        = err_reg;
  assign RX_DATA    = rx_data_reg;
  assign SPI_CK     = ck_reg;
  assign SPI_DAT    = dat_reg;
  assign CDAC_ENB   = enb_reg[DEV_CDAC];
  assign CALDAC_ENB = enb_reg[DEV_CALDAC];
  assign CALADC_ENB = enb_reg[DEV_CALADC];

endmodule

// File: tb/tb_spi_dev_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_dev_ctrl
// Directed bench for spi_dev_ctrl. Each request pushes its expected outcome
// (ERR, RX_DATA, DONE latency) onto a scoreboard queue; the entry is popped
// when DONE appears. A passive monitor tallies enable cycles per device, SPI
// clock pulses and widths, the transmitted bit stream and DONE pulses, and a
// device model returns a word on SPI_RTN, changing it as SPI_CK falls.
// Build option SPI_RTN_SYNC_EN selects CLK_DIV = 3, otherwise 4.
// -----------------------------------------------------------------------------
module tb_spi_dev_ctrl;

`ifdef SPI_RTN_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 4;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  DEV_SEL = 2'd0;
  logic [4:0]  NBITS = 5'd0;
  logic [23:0] TX_DATA = 24'd0;
  logic        BUSY, DONE, ERR;
  logic [23:0] RX_DATA;
  logic        SPI_RTN = 1'b0;
  logic        SPI_CK, SPI_DAT;
  logic        CDAC_ENB, CALDAC_ENB, CALADC_ENB;

  spi_dev_ctrl #(.CLK_DIV(D), .MAX_BITS(24)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .DEV_SEL    (DEV_SEL),
    .NBITS      (NBITS),
    .TX_DATA    (TX_DATA),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR),
    .RX_DATA    (RX_DATA),
    .SPI_RTN    (SPI_RTN),
    .SPI_CK     (SPI_CK),
    .SPI_DAT    (SPI_DAT),
    .CDAC_ENB   (CDAC_ENB),
    .CALDAC_ENB (CALDAC_ENB),
    .CALADC_ENB (CALADC_ENB)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        err;
    logic [23:0] rx;
    int          done_idx;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] last_rx = 24'd0;
  logic        aborting = 1'b0;

  // Device model inputs (written only by the stimulus).
  logic [23:0] slave_word = 24'd0;
  int          slave_nbits = 1;

  // ---------------------------------------------------------------------------
  // Monitor: sampled on the falling CLK edge, away from DUT updates.
  // ---------------------------------------------------------------------------
  int          en_cnt0 = 0, en_cnt1 = 0, en_cnt2 = 0;
  int          multi_cnt = 0, stray_cnt = 0, done_cnt = 0;
  int          ck_rises = 0, bad_width = 0, hi_run = 0;
  logic        ck_prev = 1'b0;
  logic [63:0] tx_cap = 64'd0;

  always @(negedge CLK) begin
    if (CDAC_ENB)   en_cnt0 <= en_cnt0 + 1;
    if (CALDAC_ENB) en_cnt1 <= en_cnt1 + 1;
    if (CALADC_ENB) en_cnt2 <= en_cnt2 + 1;
    if (int'(CDAC_ENB) + int'(CALDAC_ENB) + int'(CALADC_ENB) > 1) multi_cnt <= multi_cnt + 1;
    if (SPI_CK && !(CDAC_ENB || CALDAC_ENB || CALADC_ENB)) stray_cnt <= stray_cnt + 1;
    if (DONE) done_cnt <= done_cnt + 1;
    if (SPI_CK && !ck_prev) begin
      ck_rises <= ck_rises + 1;
      tx_cap   <= {tx_cap[62:0], SPI_DAT};
    end
    if (SPI_CK) begin
      hi_run <= hi_run + 1;
    end else begin
      if (ck_prev && !aborting && hi_run != D) bad_width <= bad_width + 1;
      hi_run <= 0;
    end
    ck_prev <= SPI_CK;
  end

  // ---------------------------------------------------------------------------
  // Device model: first bit when the enable rises, next bit after each SPI_CK
  // falling edge (mode 0).
  // ---------------------------------------------------------------------------
  logic any_en_prev = 1'b0;
  logic sck_prev = 1'b0;
  int   slave_idx = 0;

  always @(negedge CLK) begin
    if ((CDAC_ENB || CALDAC_ENB || CALADC_ENB) && !any_en_prev) begin
      slave_idx <= slave_nbits - 1;
      SPI_RTN   <= slave_word[slave_nbits-1];
    end else if (sck_prev && !SPI_CK && slave_idx > 0) begin
      slave_idx <= slave_idx - 1;
      SPI_RTN   <= slave_word[slave_idx-1];
    end
    any_en_prev <= CDAC_ENB || CALDAC_ENB || CALADC_ENB;
    sck_prev    <= SPI_CK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One request from START to the quiet period after DONE. mid_start >= 0
  // pulses a second START in that cycle index of the transfer.
  task automatic run_xfer(input string name, input logic [1:0] dev, input logic [4:0] nb,
                          input logic [23:0] tx, input logic [23:0] rword, input int mid_start);
    exp_t        e, got;
    bit          legal, seen;
    int          idx, e0, e1, e2, ck0, bw0, dn0, mu0, st0;
    logic [31:0] m;
    legal      = (dev != 2'd3) && (nb >= 5'd1) && (nb <= 5'd24);
    m          = (32'd1 << nb) - 32'd1;
    e.err      = !legal;
    e.rx       = legal ? (rword & m[23:0]) : last_rx;
    e.done_idx = legal ? 1 + (2 * int'(nb) + 1) * D : 0;
    sb_q.push_back(e);

    e0 = en_cnt0; e1 = en_cnt1; e2 = en_cnt2; ck0 = ck_rises; bw0 = bad_width;
    dn0 = done_cnt; mu0 = multi_cnt; st0 = stray_cnt;
    if (legal) begin
      slave_word  = rword;
      slave_nbits = int'(nb);
    end

    @(negedge CLK);
    DEV_SEL = dev; NBITS = nb; TX_DATA = tx; START = 1'b1;
    @(posedge CLK);
    seen = 1'b0;
    idx  = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      idx   = i;
      START = (i == mid_start);
      if (i == 0) begin
        // Inputs changing mid-transfer must not disturb it.
        DEV_SEL = dev ^ 2'd1; NBITS = 5'd3; TX_DATA = ~tx;
      end
      if (legal && i == 1) check({name, "_busy"}, BUSY, 1'b1);
      if (DONE) begin
        seen = 1'b1;
        break;
      end
    end
    START = 1'b0;
    check({name, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      got = sb_q.pop_front();
      check({name, "_done_cycle"}, idx, got.done_idx);
      check({name, "_err"}, ERR, got.err);
      check({name, "_busy_at_done"}, BUSY, 1'b0);
      check({name, "_rx_data"}, RX_DATA, got.rx);
      last_rx = got.rx;
    end

    repeat (2 * D + 6) @(negedge CLK);
    #1;
    check({name, "_one_done"}, done_cnt - dn0, 1);
    check({name, "_one_enable"}, multi_cnt - mu0, 0);
    check({name, "_ck_only_enabled"}, stray_cnt - st0, 0);
    if (legal) begin
      check({name, "_enb_cycles"}, (dev == 2'd0) ? en_cnt0 - e0 :
                                   (dev == 2'd1) ? en_cnt1 - e1 : en_cnt2 - e2,
            (2 * int'(nb) + 1) * D);
      check({name, "_other_enb"}, (en_cnt0 - e0) + (en_cnt1 - e1) + (en_cnt2 - e2),
            (2 * int'(nb) + 1) * D);
      check({name, "_ck_pulses"}, ck_rises - ck0, nb);
      check({name, "_ck_width"}, bad_width - bw0, 0);
      check({name, "_tx_stream"}, tx_cap & {32'd0, m}, {40'd0, tx} & {32'd0, m});
    end else begin
      check({name, "_no_enb"}, (en_cnt0 - e0) + (en_cnt1 - e1) + (en_cnt2 - e2), 0);
      check({name, "_no_ck"}, ck_rises - ck0, 0);
    end
    $display("xfer %s dev=%0d nbits=%0d tx=%06h -> done@%0d err=%0b rx=%06h",
             name, dev, nb, tx, idx, ERR, RX_DATA);
    DEV_SEL = 2'd0; NBITS = 5'd0; TX_DATA = 24'd0;
  endtask

  initial begin : stim
    int dn0, ck0;
    bit hit;

    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_rx", RX_DATA, 24'd0);
    check("rst_ck", SPI_CK, 1'b0);
    check("rst_dat", SPI_DAT, 1'b0);
    check("rst_enb", {CDAC_ENB, CALDAC_ENB, CALADC_ENB}, 3'b000);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    run_xfer("cdac_wr",   2'd0, 5'd12, 24'h000A5C, 24'h000000, -1);
    run_xfer("caladc_rd", 2'd2, 5'd16, 24'h001234, 24'h008001, -1);
    run_xfer("rej_dev3",  2'd3, 5'd8,  24'h0000FF, 24'h000000, -1);
    run_xfer("rej_nb0",   2'd1, 5'd0,  24'h0000FF, 24'h000000, -1);
    run_xfer("rej_nb25",  2'd0, 5'd25, 24'h0000FF, 24'h000000, -1);
    run_xfer("caldac_mid", 2'd1, 5'd24, 24'hC3A55A, 24'h5A5A5A, 37);
    run_xfer("one_bit",   2'd0, 5'd1,  24'h000001, 24'h000001, -1);

    // Reset during the 5th clock-high phase of a 24-bit cal DAC write.
    dn0 = done_cnt;
    ck0 = ck_rises;
    sb_q.push_back('{err: 1'b0, rx: 24'd0, done_idx: 0});
    void'(sb_q.pop_back());  // aborted transfer never completes
    @(negedge CLK);
    DEV_SEL = 2'd1; NBITS = 5'd24; TX_DATA = 24'hFFFFFF; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      #1;
      if (ck_rises - ck0 >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reach_5th_high", hit, 1'b1);
    aborting = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_enb", {CDAC_ENB, CALDAC_ENB, CALADC_ENB}, 3'b000);
    check("abort_ck", SPI_CK, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (120) @(negedge CLK);
    #1;
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_rx_cleared", RX_DATA, 24'd0);
    $display("xfer abort dev=1 nbits=24 -> reset in high phase 5, dones=%0d", done_cnt - dn0);
    aborting = 1'b0;
    last_rx  = 24'd0;

    run_xfer("after_rst_rd", 2'd2, 5'd8, 24'h000096, 24'h00003C, -1);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
